// File: rtl/chocorol_if.sv
// Host-side bundle for the chocorol compute leaf: instruction issue, memory
// load port and the registered result strobe.
interface chocorol_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
);
    logic                  instr_valid;
    logic [2*ADDR_W+7:0]   Instruccion;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic [DATA_W-1:0]     Q_final;
    logic                  q_valid;
    logic                  illegal_op;

    modport master (
        output instr_valid, Instruccion, wr_en, wr_addr, wr_data,
        input  Q_final, q_valid, illegal_op
    );

    modport slave (
        input  instr_valid, Instruccion, wr_en, wr_addr, wr_data,
        output Q_final, q_valid, illegal_op
    );
endinterface

// File: rtl/chocorol.sv
// Single-issue register-memory ALU: two operands read from a 64-word memory,
// result registered one cycle later. Define CHOCOROL_WRITEBACK_EN to also write results to Mem[DL1].
module chocorol #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    chocorol_if.slave  bus
);
    localparam int DEPTH   = 2 ** ADDR_W;
    localparam int SHAMT_W = $clog2(DATA_W);

    localparam logic [7:0] OP_ADD = 8'h00;
    localparam logic [7:0] OP_SUB = 8'h01;
    localparam logic [7:0] OP_AND = 8'h02;
    localparam logic [7:0] OP_OR  = 8'h03;
    localparam logic [7:0] OP_XOR = 8'h04;
    localparam logic [7:0] OP_SHL = 8'h05;
    localparam logic [7:0] OP_SHR = 8'h06;
    localparam logic [7:0] OP_MUL = 8'h07;

    // Register array rather than block RAM: every word has a distinct reset value
    // and both operands are read combinationally.
    logic [DATA_W-1:0] mem_reg [DEPTH];

    logic [ADDR_W-1:0]  dl1;
    logic [ADDR_W-1:0]  dl2;
    logic [7:0]         opcode;
    logic [DATA_W-1:0]  op_a;
    logic [DATA_W-1:0]  op_b;
    logic [SHAMT_W-1:0] shamt;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_illegal;

    logic [DATA_W-1:0]  q_final_reg;
    logic               q_valid_reg;
    logic               illegal_op_reg;

    assign dl1    = bus.Instruccion[2*ADDR_W+7 -: ADDR_W];
    assign dl2    = bus.Instruccion[ADDR_W+7 -: ADDR_W];
    assign opcode = bus.Instruccion[7:0];
    assign op_a   = mem_reg[dl1];
    assign op_b   = mem_reg[dl2];
    assign shamt  = op_b[SHAMT_W-1:0];

    always_comb begin
        alu_result  = '0;
        alu_illegal = 1'b0;
        case (opcode)
            OP_ADD:  alu_result = op_a + op_b;
            OP_SUB:  alu_result = op_a - op_b;
            OP_AND:  alu_result = op_a & op_b;
            OP_OR:   alu_result = op_a | op_b;
            OP_XOR:  alu_result = op_a ^ op_b;
            OP_SHL:  alu_result = op_a << shamt;
            OP_SHR:  alu_result = op_a >> shamt;
            OP_MUL:  alu_result = op_a * op_b;
            default: alu_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= DATA_W'(i);
            end
        end else begin
`ifdef CHOCOROL_WRITEBACK_EN
            if (bus.instr_valid && !alu_illegal) begin
                mem_reg[dl1] <= alu_result;
            end
`endif
            // Issued last so a host write to the same word overrides write-back.
            if (bus.wr_en) begin
                mem_reg[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q_final_reg    <= '0;
            q_valid_reg    <= 1'b0;
            illegal_op_reg <= 1'b0;
        end else begin
            q_valid_reg <= bus.instr_valid;
            if (bus.instr_valid) begin
                q_final_reg    <= alu_result;
                illegal_op_reg <= alu_illegal;
            end
        end
    end

    assign bus.Q_final    = q_final_reg;
    assign bus.q_valid    = q_valid_reg;
    assign bus.illegal_op = illegal_op_reg;
endmodule

// File: tb/tb_chocorol.sv
// Randomized self-checking bench for chocorol against an arithmetic reference model.
// Honours CHOCOROL_WRITEBACK_EN the same way as the design.
module tb_chocorol;
    logic clk = 1'b0;
    logic rst_n;

    chocorol_if #(.DATA_W(32), .ADDR_W(6)) bus ();

    chocorol #(.DATA_W(32), .ADDR_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int txn    = 0;

    longint unsigned model_mem [64];
    logic [31:0] exp_q   = 32'd0;
    logic        exp_ill = 1'b0;
    logic        exp_val = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Reference semantics from the opcode table, in 64-bit arithmetic then reduced mod 2^32.
    function automatic longint unsigned ref_alu(input logic [7:0] op, input longint unsigned a,
                                                input longint unsigned b, output logic ill);
        longint unsigned m = 64'h1_0000_0000;
        ill = 1'b0;
        case (op)
            8'h00: return (a + b) % m;
            8'h01: return (a + m - b) % m;
            8'h02: return a & b;
            8'h03: return a | b;
            8'h04: return a ^ b;
            8'h05: return (a * (64'd1 << (b % 32))) % m;
            8'h06: return a / (64'd1 << (b % 32));
            8'h07: return ((a % 65536) * b + (((a / 65536) * (b % 65536)) % 65536) * 65536) % m;
            default: begin ill = 1'b1; return 0; end
        endcase
    endfunction

    task automatic step(input logic iv, input logic [5:0] a1, input logic [5:0] a2,
                        input logic [7:0] op, input logic we, input logic [5:0] wa,
                        input logic [31:0] wd, input logic rn);
        longint unsigned res;
        logic ill;
        bus.instr_valid = iv;
        bus.Instruccion = {a1, a2, op};
        bus.wr_en       = we;
        bus.wr_addr     = wa;
        bus.wr_data     = wd;
        rst_n           = rn;
        res = 0;
        ill = 1'b0;
        if (iv) res = ref_alu(op, model_mem[a1], model_mem[a2], ill);
        @(posedge clk);
        #1;
        if (!rn) begin
            for (int i = 0; i < 64; i++) model_mem[i] = i;
            exp_q = 32'd0; exp_ill = 1'b0; exp_val = 1'b0;
        end else begin
            exp_val = iv;
            if (iv) begin
                exp_q   = res[31:0];
                exp_ill = ill;
`ifdef CHOCOROL_WRITEBACK_EN
                if (!ill) model_mem[a1] = res;
`endif
            end
            if (we) model_mem[wa] = wd;
        end
        txn++;
        $display("txn %0d rn=%0b iv=%0b op=%02h dl1=%0d dl2=%0d we=%0b wa=%0d wd=%08h -> q=%08h v=%0b ill=%0b",
                 txn, rn, iv, op, a1, a2, we, wa, wd, bus.Q_final, bus.q_valid, bus.illegal_op);
        check("q_valid", {31'd0, bus.q_valid}, {31'd0, exp_val});
        check("Q_final", bus.Q_final, exp_q);
        check("illegal_op", {31'd0, bus.illegal_op}, {31'd0, exp_ill});
    endtask

    task automatic issue(input logic [7:0] op, input logic [5:0] a1, input logic [5:0] a2);
        step(1'b1, a1, a2, op, 1'b0, 6'd0, 32'd0, 1'b1);
    endtask

    task automatic hwrite(input logic [5:0] wa, input logic [31:0] wd);
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b1, wa, wd, 1'b1);
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.Instruccion = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        rst_n           = 1'b0;

        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 6'd0, 32'd0, 1'b0);
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 6'd0, 32'd0, 1'b0);
        check("reset_q", bus.Q_final, 32'd0);

`ifdef CHOCOROL_WRITEBACK_EN
        issue(8'h00, 6'd0, 6'd1);
        check("wb_add_first", bus.Q_final, 32'd1);
        issue(8'h00, 6'd0, 6'd1);
        check("wb_add_second", bus.Q_final, 32'd2);
        step(1'b1, 6'd5, 6'd5, 8'h00, 1'b1, 6'd5, 32'd40, 1'b1);
        issue(8'h03, 6'd5, 6'd5);
        check("wb_host_wins", bus.Q_final, 32'd40);
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 6'd0, 32'd0, 1'b0);
`endif

        issue(8'h00, 6'd0, 6'd1);
        check("tp_add01", bus.Q_final, 32'd1);
        issue(8'h01, 6'd2, 6'd3);
        check("tp_sub23", bus.Q_final, 32'hFFFF_FFFF);
        issue(8'h02, 6'd4, 6'd5);
        check("tp_and45", bus.Q_final, 32'd4);
        issue(8'h03, 6'd6, 6'd7);
        check("tp_or67", bus.Q_final, 32'd7);
        check("tp_b2b_valid", {31'd0, bus.q_valid}, 32'd1);
`ifndef CHOCOROL_WRITEBACK_EN
        hwrite(6'd0, 32'd6);
        hwrite(6'd1, 32'd7);
        issue(8'h07, 6'd0, 6'd1);
        check("tp_mul42", bus.Q_final, 32'd42);
        hwrite(6'd0, 32'hFFFF_FFFF);
        issue(8'h00, 6'd0, 6'd1);
        check("tp_add_wrap", bus.Q_final, 32'd6);
        hwrite(6'd1, 32'h1_0000);
        hwrite(6'd0, 32'h1_0000);
        issue(8'h07, 6'd0, 6'd1);
        check("tp_mul_trunc", bus.Q_final, 32'd0);
        issue(8'h08, 6'd0, 6'd1);
        check("tp_illegal_q", bus.Q_final, 32'd0);
        check("tp_illegal_flag", {31'd0, bus.illegal_op}, 32'd1);
        issue(8'h00, 6'd0, 6'd1);
        check("tp_illegal_clear", {31'd0, bus.illegal_op}, 32'd0);
        step(1'b0, 6'd0, 6'd0, 8'h00, 1'b0, 6'd0, 32'd0, 1'b1);
        check("tp_idle_hold", bus.Q_final, 32'h2_0000);
        step(1'b1, 6'd3, 6'd3, 8'h00, 1'b1, 6'd3, 32'd100, 1'b1);
        check("tp_raw_old", bus.Q_final, 32'd6);
        issue(8'h00, 6'd3, 6'd3);
        check("tp_raw_new", bus.Q_final, 32'd200);
`endif

        // Reset while an instruction and a write are presented.
        step(1'b1, 6'd0, 6'd1, 8'h00, 1'b1, 6'd9, 32'd999, 1'b0);
        check("rst_mid_q", bus.Q_final, 32'd0);
        for (int a = 0; a < 64; a += 9) begin
            issue(8'h03, 6'(a), 6'(a));
            check("rst_mem_restore", bus.Q_final, 32'(a));
        end

        for (int n = 0; n < 400; n++) begin
            logic iv, we, rn;
            logic [5:0] a1, a2, wa;
            logic [7:0] op;
            logic [31:0] wd;
            iv = ($urandom_range(0, 3) != 0);
            rn = ($urandom_range(0, 59) != 0);
            op = ($urandom_range(0, 15) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
            a1 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            a2 = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            we = ($urandom_range(0, 2) == 0);
            wa = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(0, 7)) : 6'($urandom);
            wd = ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
            step(iv, a1, a2, op, we, wa, wd, rn);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
